obi_resp_port: RTL and testbench
================================

# obi_resp_port

Parametrised OBI slave responder for the core testbench memory model. One instance serves one OBI channel (instruction or data) and fronts a synchronous single-cycle RAM array. It generalises the fixed grant/rvalid behaviour of the current memory model with:
- configurable response latency;
- a bounded number of outstanding transactions;
- out-of-range error responses;
- optional pseudo-random grant stalls.

## Interface
Parameters:
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width; multiple of 8
- RAM_ADDR_WIDTH, 20, byte-address width of the backing RAM; addresses at or above 2**RAM_ADDR_WIDTH are out of range
- MAX_OUTSTANDING, 2, response FIFO depth; 1..8
- RVALID_LATENCY, 1, cycles from accept to rvalid; 1..15
- LFSR_SEED, 16'hACE1, stall LFSR seed; nonzero; used only with OBI_RESP_RANDOM_STALL_EN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  OBI request
- gnt_o  out  1  OBI grant
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  write enable
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_WIDTH  read data
- err_o  out  1  response error
- mem_req_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM write
- mem_addr_o  out  RAM_ADDR_WIDTH  RAM byte address
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after mem_req_o
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  transactions accepted but not yet responded

## Operation
- Accept is req_i && gnt_o.
- gnt_o = req_i && (outstanding < MAX_OUTSTANDING) && !stall.
  - No same-cycle bypass: a full FIFO blocks grant even if rvalid_o is high that cycle.
- In-range accept:
  - mem_req_o = 1 in the accept cycle, combinational.
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are driven from the request.
- Out-of-range accept:
  - mem_req_o = 0.
  - The entry is marked err.
- FIFO entry, written at accept: {we, err, countdown = RVALID_LATENCY-1, data}.
  - For an in-range read, data is captured from mem_rdata_i the cycle after accept.
  - For writes and errors, data is 0.
- Countdown of every valid entry decrements each cycle and saturates at 0.
- rvalid_o = head valid && head countdown == 0. rdata_o and err_o come from the head and are 0 when rvalid_o = 0. The head pops in the same cycle.
- Responses are strictly in order. The core always accepts responses (no rready).
- outstanding_o: +1 on accept, -1 on rvalid; both in one cycle leaves it unchanged.
- All state is FIFO pointers and count, entry countdowns, the LFSR and the capture flag.

## Timing
- Reset values: gnt_o = 0 (req_i gated low during reset), rvalid_o = 0, rdata_o = 0, err_o = 0, mem_req_o = 0, outstanding_o = 0. FIFO is emptied and the LFSR loads LFSR_SEED.
- Reset mid-operation: in-flight responses are discarded and never presented. A pending RAM read capture is dropped.
- Latency: accept in cycle T gives rvalid_o in cycle T+RVALID_LATENCY, provided no older response is still pending.
- Back-to-back accepts with RVALID_LATENCY=1 and MAX_OUTSTANDING>=2 give rvalid_o on every cycle.
- MAX_OUTSTANDING=1 with RVALID_LATENCY=1 gives at most one accept every 2 cycles.
- Wrap-around: FIFO pointers wrap modulo MAX_OUTSTANDING, including non-power-of-two depths. Countdown width is 4 bits.
- req_i is allowed to drop without a grant (testbench leniency). No state change results.

## Configuration
- OBI_RESP_RANDOM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - stall = LFSR[1:0] == 2'b00, giving roughly 25% grant suppression.
- Not defined:
  - stall = 0 constantly and no LFSR flops exist.
  - Grant depends only on occupancy.

## Structure
- Package obi_resp_pkg:
  - resp_entry_t struct: we, err, countdown[3:0], data.
  - LFSR_TAPS constant.
  - MAX_LATENCY = 15 constant.
- One sub-module, obi_resp_fifo: parametrised depth/width circular buffer with count, push/pop and head access, plus per-entry countdown decrement.
- Parameter legality is checked by elaboration-time assertions: latency range, depth range, nonzero seed, DATA_WIDTH%8.

## Test plan
- Reset, then single read of 0x100 with RAM word 0xDEADBEEF at RVALID_LATENCY=3 -> gnt_o in the same cycle; rvalid_o exactly 3 cycles later with rdata_o=0xDEADBEEF, err_o=0.
- Write 0x12345678 with be=4'b0011 to 0x40 -> mem_we_o=1, mem_be_o=4'b0011 in the accept cycle; rvalid_o one cycle later with rdata_o=0; readback returns 0x????5678.
- Continuous reads with MAX_OUTSTANDING=2, RVALID_LATENCY=4 -> two grants, then gnt_o=0 until the first rvalid; outstanding_o never exceeds 2; responses in order.
- Read of 0x0010_0000 with RAM_ADDR_WIDTH=20 -> mem_req_o=0; rvalid_o with err_o=1, rdata_o=0.
- rst_i asserted for one cycle with 2 reads outstanding -> no rvalid_o afterwards; outstanding_o=0 the next cycle; next accept behaves as after power-on.
- With OBI_RESP_RANDOM_STALL_EN, 1000 random requests -> grant ratio within 70–80%; every accepted transaction gets exactly one in-order response; bit-exact repeatability for a given LFSR_SEED.

Source files
------------

// File: rtl/obi_resp_pkg.sv
// Shared types and constants for the OBI response port.
// The response payload width is per-instance, so it is stored next to each entry in the FIFO.
package obi_resp_pkg;

   localparam int unsigned MAX_LATENCY = 15;
   localparam int unsigned CNTDN_W     = 4;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic               we;
      logic               err;
      logic [CNTDN_W-1:0] countdown;
   } resp_entry_t;

   function automatic logic [CNTDN_W-1:0] cntdn_dec(input logic [CNTDN_W-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// Circular response buffer: in-order entries with per-entry latency countdown and a
// late data-capture port for RAM reads that return one cycle after the push.
module obi_resp_fifo
   import obi_resp_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  push_we_i,
   input  logic                  push_err_i,
   input  logic [CNTDN_W-1:0]    push_cntdn_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   input  logic                  cap_i,
   input  logic [PTR_W-1:0]      cap_idx_i,
   input  logic [DATA_WIDTH-1:0] cap_data_i,
   output logic                  head_valid_o,
   output logic                  head_we_o,
   output logic                  head_err_o,
   output logic [CNTDN_W-1:0]    head_cntdn_o,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic [PTR_W-1:0]      head_idx_o,
   output logic [PTR_W-1:0]      tail_idx_o,
   output logic [CNT_W-1:0]      count_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   resp_entry_t           ent_vec  [DEPTH];
   logic [DATA_WIDTH-1:0] data_vec [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      resp_entry_t           ent_q, ent_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  wr_hit, cap_hit;

      assign wr_hit  = push_i && (wr_ptr_q == PTR_W'(gi));
      assign cap_hit = cap_i && (cap_idx_i == PTR_W'(gi));

      // Stale slots keep counting down too; a push always overwrites them first.
      always_comb begin
         ent_d           = ent_q;
         data_d          = data_q;
         ent_d.countdown = cntdn_dec(ent_q.countdown);
         if (cap_hit) begin
            data_d = cap_data_i;
         end
         if (wr_hit) begin
            ent_d.we        = push_we_i;
            ent_d.err       = push_err_i;
            ent_d.countdown = push_cntdn_i;
            data_d          = push_data_i;
         end
      end

      always_ff @(posedge clk_i) begin
         ent_q  <= ent_d;
         data_q <= data_d;
      end

      assign ent_vec[gi]  = ent_q;
      assign data_vec[gi] = data_q;
   end

   assign head_valid_o = (count_q != '0);
   assign head_we_o    = ent_vec[rd_ptr_q].we;
   assign head_err_o   = ent_vec[rd_ptr_q].err;
   assign head_cntdn_o = ent_vec[rd_ptr_q].countdown;
   assign head_data_o  = data_vec[rd_ptr_q];
   assign head_idx_o   = rd_ptr_q;
   assign tail_idx_o   = wr_ptr_q;
   assign count_o      = count_q;

endmodule

// File: rtl/obi_resp_port.sv
// OBI slave responder fronting a single-cycle RAM: bounded outstanding, fixed latency, range errors.
// Optional pseudo-random grant stalls are enabled by defining OBI_RESP_RANDOM_STALL_EN.
module obi_resp_port
   import obi_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned RAM_ADDR_WIDTH  = 20,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned RVALID_LATENCY  = 1,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   req_i,
   output logic                                   gnt_o,
   input  logic [ADDR_WIDTH-1:0]                  addr_i,
   input  logic                                   we_i,
   input  logic [DATA_WIDTH/8-1:0]                be_i,
   input  logic [DATA_WIDTH-1:0]                  wdata_i,
   output logic                                   rvalid_o,
   output logic [DATA_WIDTH-1:0]                  rdata_o,
   output logic                                   err_o,
   output logic                                   mem_req_o,
   output logic                                   mem_we_o,
   output logic [RAM_ADDR_WIDTH-1:0]              mem_addr_o,
   output logic [DATA_WIDTH/8-1:0]                mem_be_o,
   output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   if (RVALID_LATENCY < 1 || RVALID_LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("obi_resp_port: RVALID_LATENCY must be 1..15");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_depth
      $error("obi_resp_port: MAX_OUTSTANDING must be 1..8");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("obi_resp_port: LFSR_SEED must be nonzero");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("obi_resp_port: DATA_WIDTH must be a multiple of 8");
   end
   if (RAM_ADDR_WIDTH > ADDR_WIDTH) begin : g_bad_ram_width
      $error("obi_resp_port: RAM_ADDR_WIDTH must not exceed ADDR_WIDTH");
   end

   logic stall;

`ifdef OBI_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   logic in_range;
   if (ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_range_chk
      assign in_range = ~|addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH];
   end else begin : g_range_all
      assign in_range = 1'b1;
   end

   logic                  head_valid, head_we, head_err;
   logic [CNTDN_W-1:0]    head_cntdn;
   logic [DATA_WIDTH-1:0] head_data;
   logic [PTR_W-1:0]      head_idx, tail_idx;
   logic [CNT_W-1:0]      count;
   logic                  accept, has_space, head_fresh;

   logic             cap_q, cap_d;
   logic [PTR_W-1:0] cap_idx_q, cap_idx_d;

   // Grant looks only at registered occupancy, so a full FIFO blocks even while it pops.
   assign has_space = (count < CNT_W'(MAX_OUTSTANDING));
   assign gnt_o     = req_i && !rst_i && has_space && !stall;
   assign accept    = gnt_o;

   assign mem_req_o   = accept && in_range;
   assign mem_we_o    = mem_req_o && we_i;
   assign mem_addr_o  = addr_i[RAM_ADDR_WIDTH-1:0];
   assign mem_be_o    = be_i;
   assign mem_wdata_o = wdata_i;

   always_comb begin
      cap_d     = mem_req_o && !we_i;
      cap_idx_d = tail_idx;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cap_q     <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         cap_q     <= cap_d;
         cap_idx_q <= cap_idx_d;
      end
   end

   obi_resp_fifo #(
      .DEPTH      (MAX_OUTSTANDING),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (accept),
      .push_we_i    (we_i),
      .push_err_i   (!in_range),
      .push_cntdn_i (CNTDN_W'(RVALID_LATENCY - 1)),
      .push_data_i  ('0),
      .pop_i        (rvalid_o),
      .cap_i        (cap_q),
      .cap_idx_i    (cap_idx_q),
      .cap_data_i   (mem_rdata_i),
      .head_valid_o (head_valid),
      .head_we_o    (head_we),
      .head_err_o   (head_err),
      .head_cntdn_o (head_cntdn),
      .head_data_o  (head_data),
      .head_idx_o   (head_idx),
      .tail_idx_o   (tail_idx),
      .count_o      (count)
   );

   // At latency 1 the read data arrives the same cycle the head is due, so bypass it.
   assign head_fresh = cap_q && (cap_idx_q == head_idx) && !head_we;

   assign rvalid_o      = !rst_i && head_valid && (head_cntdn == '0);
   assign rdata_o       = rvalid_o ? (head_fresh ? mem_rdata_i : head_data) : '0;
   assign err_o         = rvalid_o && head_err;
   assign outstanding_o = count;

endmodule

// File: tb/tb_obi_resp_port.sv
// Directed and random checks of obi_resp_port against a scoreboard and a reference memory.
module tb_obi_resp_port;

   localparam int          MAX  = 3;
   localparam int          LAT  = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic [31:0] addr_i = '0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [19:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic [1:0]  outstanding_o;

   always #5 clk = ~clk;

   obi_resp_port #(
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .RAM_ADDR_WIDTH  (20),
      .MAX_OUTSTANDING (MAX),
      .RVALID_LATENCY  (LAT),
      .LFSR_SEED       (SEED)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .gnt_o         (gnt_o),
      .addr_i        (addr_i),
      .we_i          (we_i),
      .be_i          (be_i),
      .wdata_i       (wdata_i),
      .rvalid_o      (rvalid_o),
      .rdata_o       (rdata_o),
      .err_o         (err_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_be_o      (mem_be_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i),
      .outstanding_o (outstanding_o)
   );

   function automatic logic [31:0] pat(input int i);
      return (i == 64) ? 32'hDEADBEEF : 32'h5A000000 + 32'(i) * 32'h00010203;
   endfunction

   // Synchronous single-cycle RAM behind the port
   logic [31:0] ram [256];
   logic        ram_loaded = 1'b0;

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= pat(i);
         ram_loaded <= 1'b1;
      end else if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= ram[mem_addr_o[9:2]];
         end
      end
   end

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [256];
   logic [15:0] lfsr = SEED;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_due = -1;
   int          reqs_space = 0;
   int          grants = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already driven; outputs are sampled on the falling edge.
   task automatic step();
      logic exp_gnt, exp_rv, in_rng, space;
      exp_t e;
      int   idx;
      @(negedge clk);
      if (rst_i) begin
         chk("gnt_in_reset", gnt_o, 0);
         chk("rvalid_in_reset", rvalid_o, 0);
         chk("mem_req_in_reset", mem_req_o, 0);
      end else begin
         chk("outstanding_o", outstanding_o, sb.size());
         space   = (sb.size() < MAX);
         exp_gnt = req_i && space;
`ifdef OBI_RESP_RANDOM_STALL_EN
         exp_gnt = exp_gnt && (lfsr[1:0] != 2'b00);
`endif
         if (req_i && space) begin
            reqs_space++;
            if (gnt_o) grants++;
         end
         chk("gnt_o", gnt_o, exp_gnt);
         exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
         chk("rvalid_o", rvalid_o, exp_rv);
         if (rvalid_o && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdata_o", rdata_o, e.data);
            chk("err_o", err_o, e.err);
            $display("resp cyc=%0d rdata=%h err=%b", cyc, rdata_o, err_o);
         end else if (!rvalid_o) begin
            chk("rdata_idle", rdata_o, 0);
            chk("err_idle", err_o, 0);
         end
         if (gnt_o) begin
            in_rng = (addr_i[31:20] == 12'h000);
            chk("mem_req_o", mem_req_o, in_rng);
            e.err  = !in_rng;
            e.data = '0;
            if (in_rng) begin
               chk("mem_we_o", mem_we_o, we_i);
               chk("mem_addr_o", mem_addr_o, addr_i[19:0]);
               idx = int'(addr_i[9:2]);
               if (we_i) begin
                  chk("mem_be_o", mem_be_o, be_i);
                  chk("mem_wdata_o", mem_wdata_o, wdata_i);
                  for (int b = 0; b < 4; b++)
                     if (be_i[b]) ref_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
               end else begin
                  e.data = ref_mem[idx];
               end
            end
            e.due    = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
            last_due = e.due;
            sb.push_back(e);
         end else begin
            chk("mem_req_idle", mem_req_o, 0);
         end
      end
      @(posedge clk);
      if (rst_i) begin
         sb.delete();
         last_due = -1;
         lfsr     = SEED;
      end else begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      cyc++;
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
      req_i   = req;
      we_i    = we;
      addr_i  = addr;
      be_i    = be;
      wdata_i = wdata;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (n) step();
   endtask

   initial begin
      logic [7:0] w;
      int         n_rand;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

      // Power-on reset
      rst_i = 1'b1;
      repeat (3) step();
      rst_i = 1'b0;
      idle(2);

      // Single read of 0x100, response LAT cycles later
      drive(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
      step();
      idle(LAT + 1);

      // Partial write then readback of 0x40
      drive(1'b1, 1'b1, 32'h0000_0040, 4'b0011, 32'h1234_5678);
      step();
      drive(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
      step();
      idle(LAT + 2);

      // Continuous reads fill the FIFO; grant resumes only after a response pops
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b0, 32'(k * 4), 4'hF, 32'h0);
         step();
      end
      idle(LAT + MAX + 2);

      // Out-of-range read and write
      drive(1'b1, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
      step();
      drive(1'b1, 1'b1, 32'hFFFF_FFF0, 4'hF, 32'hCAFE_F00D);
      step();
      idle(LAT + 2);

      // Reset with two reads in flight: nothing may be presented afterwards
      drive(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'h0);
      step();
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      idle(LAT + 3);
      drive(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
      step();
      idle(LAT + 1);

      // Random traffic, including out-of-range and requests dropped without grant
`ifdef OBI_RESP_RANDOM_STALL_EN
      n_rand = 1000;
`else
      n_rand = 300;
`endif
      reqs_space = 0;
      grants     = 0;
      for (int k = 0; k < n_rand; k++) begin
         w = 8'($urandom_range(0, 255));
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0) ? 32'h0010_0000 : {22'd0, w, 2'b00},
               4'($urandom_range(0, 15)), $urandom());
         step();
      end

      // Bounded drain
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      for (int k = 0; k < 60 && sb.size() > 0; k++) step();
      chk("drain_empty", sb.size(), 0);
      idle(2);

`ifdef OBI_RESP_RANDOM_STALL_EN
      chk("grant_ratio_70_80", (grants * 100 >= reqs_space * 70) && (grants * 100 <= reqs_space * 80), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
